// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor control blocks.
// - motor_state_t : sequencer state encoding, as seen on the STATE status port.
// - MDU_*         : bit positions inside the MOD_DELAY_UMIN configuration word.
// - MDU_DEFAULT   : configuration word applied at reset (vector modulation).
// - pack_mdu      : assembles {MOD_SEL, DELAY_CFG, UMIN_CFG, 1'b0}.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RAMP       = 3'd1,
    RUN        = 3'd2,
    STOP_RAMP  = 3'd3,
    FAULTED_ST = 3'd4
  } motor_state_t;

  localparam int          MDU_MOD_SEL_BIT = 15;  // bit 15
  localparam int          MDU_DELAY_LSB   = 8;   // bits 14:8
  localparam int          MDU_UMIN_LSB    = 1;   // bits 7:1, bit 0 stays 0
  localparam logic [15:0] MDU_DEFAULT     = 16'h8000;

  function automatic logic [15:0] pack_mdu(input logic       mod_sel,
                                           input logic [6:0] delay_cfg,
                                           input logic [6:0] umin_cfg);
    logic [15:0] word;
    word                       = '0;
    word[MDU_MOD_SEL_BIT]      = mod_sel;
    word[MDU_DELAY_LSB +: 7]   = delay_cfg;
    word[MDU_UMIN_LSB +: 7]    = umin_cfg;
    return word;
  endfunction

endpackage

// File: rtl/motor_tick_div.sv
// Ramp prescaler: counts 0..DIV while enabled and pulses TICK for one cycle
// at the top of the count, then wraps. Held at 0 while disabled, so the first
// tick after enabling arrives DIV+1 cycles later.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset
//   EN   - run the counter (0 clears it)
//   DIV  - tick period minus one, in CLK cycles
//   TICK - one-cycle tick pulse
module motor_tick_div #(
  parameter int tick_div_bits = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [tick_div_bits-1:0] DIV,
  output logic                     TICK
);

  logic [tick_div_bits-1:0] count;

  // ">=" rather than "==" so that lowering DIV below the current count while
  // running wraps immediately instead of running the full counter range.
  assign TICK = EN && (count >= DIV);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (!EN || TICK) begin
      count <= '0;
    end else begin
      count <= count + tick_div_bits'(1);
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Motor power ramp sequencer. Ramps POWER toward TARGET_POWER in RAMP_STEP
// increments on prescaler ticks, holds in RUN, ramps to zero on stop, and
// drops to zero immediately on FAULT.
// Ports:
//   CLK, RST                   - clock, asynchronous active-high reset
//   START, STOP, FAULT         - level requests (priority FAULT > STOP > START)
//   FAULT_CLR                  - pulse, leaves FAULTED_ST when FAULT is low
//   TARGET_POWER, RAMP_STEP    - setpoint and per-tick step (0 acts as 1)
//   TICK_DIV                   - ramp tick period minus one
//   MOD_SEL, DELAY_CFG, UMIN_CFG - drive config, sampled only in IDLE
//   POWER, MOD_DELAY_UMIN      - registered power command and config word
//   STATE, RUNNING, AT_SPEED, FAULTED - registered status
module motor_ramp_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int resolution_bits = 12,
  parameter int tick_div_bits   = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       FAULT,
  input  logic                       FAULT_CLR,
  input  logic [resolution_bits-1:0] TARGET_POWER,
  input  logic [7:0]                 RAMP_STEP,
  input  logic [tick_div_bits-1:0]   TICK_DIV,
  input  logic                       MOD_SEL,
  input  logic [6:0]                 DELAY_CFG,
  input  logic [6:0]                 UMIN_CFG,
  output logic [resolution_bits-1:0] POWER,
  output logic [15:0]                MOD_DELAY_UMIN,
  output logic [2:0]                 STATE,
  output logic                       RUNNING,
  output logic                       AT_SPEED,
  output logic                       FAULTED
);

  localparam int RW = resolution_bits + 1;

  motor_state_t               state_reg, state_next;
  logic [resolution_bits-1:0] power_reg, power_next;
  logic [15:0]                mdu_reg;
  logic                       running_reg, running_next;
  logic                       at_speed_reg, at_speed_next;
  logic                       faulted_reg, faulted_next;
  logic                       tick;
  logic                       stop_req;

  logic [RW-1:0]              step_ext, pow_ext, tgt_ext, up_sum, down_val;
  logic [resolution_bits-1:0] toward_target, toward_zero;

  motor_tick_div #(.tick_div_bits(tick_div_bits)) u_tick_div (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (running_reg),
    .DIV  (TICK_DIV),
    .TICK (tick)
  );

  assign stop_req = STOP || !START;

  // Ramp arithmetic in one extra bit so the upward sum cannot wrap before
  // the clamp compares it with the target.
  always_comb begin
    step_ext      = (RAMP_STEP == 8'd0) ? RW'(1) : RW'(RAMP_STEP);
    pow_ext       = RW'(power_reg);
    tgt_ext       = RW'(TARGET_POWER);
    up_sum        = pow_ext + step_ext;
    down_val      = pow_ext - step_ext;
    toward_target = TARGET_POWER;
    if (pow_ext < tgt_ext) begin
      toward_target = (up_sum >= tgt_ext) ? TARGET_POWER : up_sum[resolution_bits-1:0];
    end else if (pow_ext > tgt_ext) begin
      toward_target = ((pow_ext - tgt_ext) <= step_ext) ? TARGET_POWER
                                                        : down_val[resolution_bits-1:0];
    end
    toward_zero = (pow_ext <= step_ext) ? '0 : down_val[resolution_bits-1:0];
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and next power
  always_comb begin
    state_next = state_reg;
    power_next = power_reg;
    case (state_reg)
      IDLE: begin
        if (START && !STOP) state_next = RAMP;
      end
      RAMP: begin
        if (stop_req) begin
          state_next = STOP_RAMP;
        end else begin
          if (power_reg == TARGET_POWER) state_next = RUN;
          if (tick) power_next = toward_target;
        end
      end
      RUN: begin
        if (stop_req) state_next = STOP_RAMP;
        else if (power_reg != TARGET_POWER) state_next = RAMP;
      end
      STOP_RAMP: begin
        if (power_reg == '0) state_next = IDLE;
        else if (tick) power_next = toward_zero;
      end
      FAULTED_ST: begin
        power_next = '0;
        if (FAULT_CLR) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        power_next = '0;
      end
    endcase
    if (FAULT) begin
      state_next = FAULTED_ST;
      power_next = '0;
    end
  end

  // Status decode from the next state so the registered flags line up with
  // the state register they describe.
  always_comb begin
    running_next  = (state_next == RAMP) || (state_next == RUN) ||
                    (state_next == STOP_RAMP);
    at_speed_next = (state_next == RUN);
    faulted_next  = (state_next == FAULTED_ST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      power_reg    <= '0;
      mdu_reg      <= MDU_DEFAULT;
      running_reg  <= 1'b0;
      at_speed_reg <= 1'b0;
      faulted_reg  <= 1'b0;
    end else begin
      power_reg    <= power_next;
      running_reg  <= running_next;
      at_speed_reg <= at_speed_next;
      faulted_reg  <= faulted_next;
      if (state_reg == IDLE) begin
        mdu_reg <= pack_mdu(MOD_SEL, DELAY_CFG, UMIN_CFG);
      end
    end
  end

  assign POWER          = power_reg;
  assign MOD_DELAY_UMIN = mdu_reg;
  assign STATE          = state_reg;
  assign RUNNING        = running_reg;
  assign AT_SPEED       = at_speed_reg;
  assign FAULTED        = faulted_reg;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: inputs driven and outputs sampled
// on the falling clock edge, expected values worked out by hand.
module tb_motor_ramp_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, STOP = 1'b0, FAULT = 1'b0, FAULT_CLR = 1'b0;
  logic [11:0] TARGET_POWER = 12'd0;
  logic [7:0]  RAMP_STEP = 8'd0;
  logic [15:0] TICK_DIV = 16'd0;
  logic        MOD_SEL = 1'b1;
  logic [6:0]  DELAY_CFG = 7'd0, UMIN_CFG = 7'd0;
  logic [11:0] POWER;
  logic [15:0] MOD_DELAY_UMIN;
  logic [2:0]  STATE;
  logic        RUNNING, AT_SPEED, FAULTED;

  int checks = 0;
  int errors = 0;

  motor_ramp_sequencer #(.resolution_bits(12), .tick_div_bits(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .FAULT(FAULT),
    .FAULT_CLR(FAULT_CLR), .TARGET_POWER(TARGET_POWER), .RAMP_STEP(RAMP_STEP),
    .TICK_DIV(TICK_DIV), .MOD_SEL(MOD_SEL), .DELAY_CFG(DELAY_CFG),
    .UMIN_CFG(UMIN_CFG), .POWER(POWER), .MOD_DELAY_UMIN(MOD_DELAY_UMIN),
    .STATE(STATE), .RUNNING(RUNNING), .AT_SPEED(AT_SPEED), .FAULTED(FAULTED)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    for (int i = 0; i < budget && STATE !== exp; i++) @(negedge CLK);
    check_eq(tag, STATE, exp);
  endtask

  task automatic wait_power_change(input int budget, output logic [11:0] val);
    logic [11:0] old;
    old = POWER;
    for (int i = 0; i < budget && POWER === old; i++) @(negedge CLK);
    val = POWER;
  endtask

  logic [11:0] pv;

  initial begin
    // Reset state
    cyc(2);
    check_eq("rst_power", POWER, 0);
    check_eq("rst_state", STATE, 0);
    check_eq("rst_mdu", MOD_DELAY_UMIN, 16'h8000);
    check_eq("rst_flags", {RUNNING, AT_SPEED, FAULTED}, 0);
    RST = 1'b0;
    cyc(2);
    check_eq("idle_mdu", MOD_DELAY_UMIN, 16'h8000);

    // Ramp 0 -> 1000 by 100, one tick every 4 cycles
    TICK_DIV = 16'd3; RAMP_STEP = 8'd100; TARGET_POWER = 12'd1000; START = 1'b1;
    cyc(1);
    check_eq("ramp_enter_state", STATE, 1);
    check_eq("ramp_enter_power", POWER, 0);
    check_eq("ramp_running", RUNNING, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc(3);
      check_eq($sformatf("ramp_hold_%0d", k), POWER, 100 * (k - 1));
      cyc(1);
      check_eq($sformatf("ramp_step_%0d", k), POWER, 100 * k);
    end
    check_eq("ramp_top_state", STATE, 1);
    check_eq("ramp_top_at_speed", AT_SPEED, 0);
    cyc(1);
    check_eq("run_state", STATE, 2);
    check_eq("run_at_speed", AT_SPEED, 1);

    // Retrack down 1000 -> 850
    TARGET_POWER = 12'd850;
    cyc(1);
    check_eq("retrack_state", STATE, 1);
    check_eq("retrack_at_speed", AT_SPEED, 0);
    wait_power_change(20, pv);
    check_eq("retrack_900", pv, 900);
    wait_power_change(20, pv);
    check_eq("retrack_850", pv, 850);
    check_eq("retrack_850_state", STATE, 1);
    cyc(1);
    check_eq("retrack_run", STATE, 2);

    // Down to 500 then controlled stop, step 200, tick every cycle
    TICK_DIV = 16'd0; TARGET_POWER = 12'd500; RAMP_STEP = 8'd200;
    cyc(1);
    check_eq("to500_state", STATE, 1);
    wait_state("to500_run", 2, 20);
    check_eq("to500_power", POWER, 500);
    STOP = 1'b1;
    cyc(1);
    check_eq("stop_state", STATE, 3);
    check_eq("stop_power", POWER, 500);
    cyc(1); check_eq("stop_300", POWER, 300);
    cyc(1); check_eq("stop_100", POWER, 100);
    cyc(1); check_eq("stop_0", POWER, 0);
    check_eq("stop_0_state", STATE, 3);
    cyc(1);
    check_eq("stop_idle", STATE, 0);
    check_eq("stop_running", RUNNING, 0);
    START = 1'b0; STOP = 1'b0;

    // Saturation at full scale, 255 per cycle
    TARGET_POWER = 12'd4095; RAMP_STEP = 8'd255; TICK_DIV = 16'd0; START = 1'b1;
    cyc(1);
    check_eq("sat_enter", STATE, 1);
    cyc(16); check_eq("sat_4080", POWER, 4080);
    cyc(1);  check_eq("sat_4095", POWER, 4095);
    cyc(1);  check_eq("sat_run", STATE, 2);
    cyc(3);  check_eq("sat_nowrap", POWER, 4095);

    // Down to 700, then FAULT+STOP+START together
    TARGET_POWER = 12'd700;
    cyc(1);
    check_eq("to700_state", STATE, 1);
    wait_state("to700_run", 2, 40);
    check_eq("to700_power", POWER, 700);
    FAULT = 1'b1; STOP = 1'b1;
    cyc(1);
    check_eq("fault_power", POWER, 0);
    check_eq("fault_flag", FAULTED, 1);
    check_eq("fault_state", STATE, 4);
    check_eq("fault_running", RUNNING, 0);
    FAULT_CLR = 1'b1;
    cyc(1);
    check_eq("fault_clr_ignored", STATE, 4);
    FAULT = 1'b0; FAULT_CLR = 1'b0; STOP = 1'b0; START = 1'b0;
    cyc(2);
    check_eq("fault_held", FAULTED, 1);
    FAULT_CLR = 1'b1;
    cyc(1);
    FAULT_CLR = 1'b0;
    check_eq("fault_cleared_state", STATE, 0);
    check_eq("fault_cleared_flag", FAULTED, 0);

    // Config capture only in IDLE
    MOD_SEL = 1'b0; DELAY_CFG = 7'h2A; UMIN_CFG = 7'h15;
    cyc(1);
    check_eq("cfg_idle_capture", MOD_DELAY_UMIN, 16'h2A2A);
    TARGET_POWER = 12'd300; RAMP_STEP = 8'd100; START = 1'b1;
    wait_state("cfg_run", 2, 20);
    MOD_SEL = 1'b1; DELAY_CFG = 7'h7F;
    cyc(2);
    check_eq("cfg_run_hold", MOD_DELAY_UMIN, 16'h2A2A);
    START = 1'b0;
    wait_state("cfg_back_idle", 0, 20);
    check_eq("cfg_idle_first", MOD_DELAY_UMIN, 16'h2A2A);
    cyc(1);
    check_eq("cfg_recapture", MOD_DELAY_UMIN, 16'hFF2A);

    // Reset mid-ramp
    TARGET_POWER = 12'd1000; RAMP_STEP = 8'd100; TICK_DIV = 16'd0; START = 1'b1;
    cyc(3);
    check_eq("prerst_power", POWER, 200);
    RST = 1'b1;
    #1;
    check_eq("midrst_power", POWER, 0);
    check_eq("midrst_state", STATE, 0);
    check_eq("midrst_mdu", MOD_DELAY_UMIN, 16'h8000);
    check_eq("midrst_flags", {RUNNING, AT_SPEED, FAULTED}, 0);
    TICK_DIV = 16'd3;
    cyc(1);
    RST = 1'b0;
    cyc(1);
    check_eq("restart_state", STATE, 1);
    check_eq("restart_power", POWER, 0);
    cyc(3);
    check_eq("restart_hold", POWER, 0);
    cyc(1);
    check_eq("restart_first_step", POWER, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_ramp_sequencer.md
MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

Interface
REQ-001 SHALL have parameter resolution_bits, default 12: width of the POWER path.
REQ-002 SHALL have parameter tick_div_bits, default 16: width of the ramp prescaler.
REQ-003 SHALL have port CLK, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port START, input, 1: level request to run.
REQ-006 SHALL have port STOP, input, 1: level request for a controlled ramp to zero.
REQ-007 SHALL have port FAULT, input, 1: level; immediate shutdown.
REQ-008 SHALL have port FAULT_CLR, input, 1: pulse; leaves the FAULT state.
REQ-009 SHALL have port TARGET_POWER, input, resolution_bits: setpoint.
REQ-010 SHALL have port RAMP_STEP, input, 8: POWER increment per tick.
REQ-011 SHALL have port TICK_DIV, input, tick_div_bits: tick period minus 1, in CLK cycles.
REQ-012 SHALL have ports MOD_SEL (1), DELAY_CFG (7) and UMIN_CFG (7), all inputs: drive-stage configuration.
REQ-013 SHALL have port POWER, output, resolution_bits: registered power command to the motor drive.
REQ-014 SHALL have port MOD_DELAY_UMIN, output, 16: registered config word {MOD_SEL, DELAY_CFG, UMIN_CFG, 1'b0}.
REQ-015 SHALL have ports STATE (output, 3), RUNNING (output, 1), AT_SPEED (output, 1) and FAULTED (output, 1): status.

Function
REQ-016 SHALL implement states IDLE, RAMP, RUN, STOP_RAMP and FAULTED_ST, encoded on STATE as 0 to 4.
REQ-017 SHALL run a prescaler counting 0 to TICK_DIV and pulse tick for one cycle when count equals TICK_DIV, then wrap to 0; TICK_DIV=0 gives a tick every cycle.
REQ-018 SHALL hold the prescaler at 0 in IDLE and FAULTED_ST, so the first tick after entering RAMP comes TICK_DIV+1 cycles later.
REQ-019 SHALL treat an effective step of RAMP_STEP=0 as 1.
REQ-020 SHALL, in RAMP on tick, move POWER toward TARGET_POWER by the step, computed in resolution_bits+1 bits, clamped so it never overshoots the target or leaves 0 to 2**resolution_bits-1.
REQ-021 SHALL leave IDLE for RAMP when START=1, STOP=0 and FAULT=0.
REQ-022 SHALL go from RAMP to RUN in the cycle after POWER equals TARGET_POWER.
REQ-023 SHALL go from RUN to RAMP when TARGET_POWER differs from POWER, retracking up or down.
REQ-024 SHALL go from RAMP or RUN to STOP_RAMP when STOP=1 or START=0.
REQ-025 SHALL, in STOP_RAMP on tick, decrease POWER by the step, clamped at 0, and go to IDLE in the cycle after POWER equals 0.
REQ-026 SHALL, from any state with FAULT=1, set POWER to 0 on the next edge and enter FAULTED_ST.
REQ-027 SHALL leave FAULTED_ST for IDLE only on FAULT_CLR=1 with FAULT=0.
REQ-028 SHALL apply event priority FAULT, then STOP, then START when they arrive in the same cycle.
REQ-029 SHALL capture MOD_DELAY_UMIN from the config inputs only while in IDLE and hold it in every other state.
REQ-030 SHALL drive RUNNING=1 in RAMP, RUN and STOP_RAMP.
REQ-031 SHALL drive AT_SPEED=1 only in RUN.
REQ-032 SHALL drive FAULTED=1 only in FAULTED_ST.
REQ-033 SHALL register all outputs, giving one cycle of latency from the state or POWER update.

Reset
REQ-034 SHALL, on RST=1, asynchronously set POWER=0, MOD_DELAY_UMIN=16'h8000 (vector modulation default), STATE=IDLE, prescaler=0, RUNNING=0, AT_SPEED=0, FAULTED=0.
REQ-035 SHALL, on reset asserted mid-ramp, abort at once with no ramp-down; after release the block SHALL restart from IDLE.

Structure
REQ-036 SHALL take the state encoding, the MOD_DELAY_UMIN bit positions and the default config 16'h8000 from shared package motor_ctrl_pkg.
REQ-037 SHALL place the prescaler in sub-module motor_tick_div (inputs CLK, RST, EN, DIV; output TICK).

Verification
REQ-038 SHALL cover: TICK_DIV=3, RAMP_STEP=100, TARGET_POWER=1000, START -> POWER 100, 200, ... 1000 every 4 cycles, then RUN with AT_SPEED=1.
REQ-039 SHALL cover: TARGET_POWER=4095, RAMP_STEP=255, TICK_DIV=0 -> POWER saturates at 4095 with no wrap.
REQ-040 SHALL cover: in RUN at 1000, TARGET_POWER=850, RAMP_STEP=100 -> POWER 900 then 850, then RUN.
REQ-041 SHALL cover: STOP at POWER=500, step 200 -> POWER 300, 100, 0, then IDLE and RUNNING=0.
REQ-042 SHALL cover: FAULT, STOP and START asserted in the same cycle at POWER=700 -> next edge POWER=0 and FAULTED=1; FAULT_CLR while FAULT=1 is ignored.
REQ-043 SHALL cover: MOD_SEL or DELAY_CFG changed during RUN -> MOD_DELAY_UMIN unchanged until back in IDLE, and RST mid-ramp -> all reset values at once.
